hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter WAIT_TIMEOUT, default 255: maximum data-memory wait cycles before bus error.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall counter.
REQ-003 SHALL have ports `clk` (in, 1, sole clock, rising edge) and `rst_n` (in, 1, asynchronous active-low reset).
REQ-004 SHALL have port IDEX_mem_read (in, 1): the instruction in EX is a load.
REQ-005 SHALL have ports IDEX_Rt, IFID_Rs and IFID_Rt (in, 5 each): register fields of the EX and ID stages.
REQ-006 SHALL have port branch_taken (in, 1): branch resolved taken in ID.
REQ-007 SHALL have ports dmem_req (in, 1, MEM stage access) and dmem_ready (in, 1, memory completes the access this cycle).
REQ-008 SHALL have ports pc_we, IFID_we, IDEX_we and EXMEM_we (out, 1 each): pipeline register enables.
REQ-009 SHALL have ports IFID_flush, IDEX_bubble and MEMWB_bubble (out, 1 each): insert a NOP into the named register.
REQ-010 SHALL have port bus_err (out, 1): sticky memory-timeout flag.
REQ-011 SHALL have port stall_cnt (out, CNT_W): stalled-cycle count, present only under the configuration macro.

Function
REQ-012 SHALL implement the FSM states RUN, MEM_WAIT and ERROR, with outputs decoded combinationally from state and inputs.
REQ-013 RUN with dmem_req=1 and dmem_ready=0 SHALL, in the same cycle, drive pc_we, IFID_we, IDEX_we and EXMEM_we to 0 and MEMWB_bubble to 1, then go to MEM_WAIT.
REQ-014 MEM_WAIT with dmem_ready=0 SHALL hold the freeze of REQ-013 and increment a wait counter.
REQ-015 MEM_WAIT with dmem_ready=1 SHALL release all enables in that cycle, return to RUN and clear the wait counter.
REQ-016 When the wait counter reaches WAIT_TIMEOUT in MEM_WAIT with dmem_ready still 0, the FSM SHALL go to ERROR.
REQ-017 ERROR SHALL drive all enables to 0 and bus_err to 1, and SHALL exit only on reset.
REQ-018 In RUN without a memory stall, a load-use hazard (IDEX_mem_read=1, IDEX_Rt!=0, and IDEX_Rt equals IFID_Rs or IFID_Rt) SHALL drive pc_we=0, IFID_we=0 and IDEX_bubble=1 for that cycle, with IDEX_we=1 and EXMEM_we=1.
REQ-019 In RUN with no stall, branch_taken=1 SHALL drive IFID_flush=1 with all enables 1.
REQ-020 Priority SHALL be memory stall > load-use > branch flush; a suppressed branch_taken SHALL be ignored, since ID holds and re-presents it.
REQ-021 IFID_flush and IDEX_bubble SHALL be 0 in MEM_WAIT and ERROR.
REQ-022 Absent any hazard, all enables SHALL be 1 and all flush/bubble outputs 0.

Reset
REQ-023 rst_n low SHALL immediately force state RUN, the wait counter to 0, stall_cnt to 0 and bus_err to 0.
REQ-024 While rst_n is low, every enable and every flush/bubble output SHALL be 0, including when reset is asserted mid-MEM_WAIT.

Configuration
REQ-025 Macro HAZARD_STALL_CNT_EN defined SHALL compile in stall_cnt.
REQ-026 stall_cnt SHALL increment by 1 on every cycle with pc_we=0 outside reset and ERROR, and SHALL saturate at all-ones.
REQ-027 Macro HAZARD_STALL_CNT_EN undefined SHALL remove the stall_cnt port and its counter, with no other behavioural change.

Structure
REQ-028 The FSM state encoding (2-bit typedef) SHALL live in the shared pipeline package.
REQ-029 The register-zero constant (5'd0) SHALL live in the shared pipeline package.
REQ-030 Load-use detection SHALL be a sub-module load_use_detect (purely combinational); the FSM and counters SHALL remain in hazard_ctrl.

Verification
REQ-031 IDEX_mem_read=1, IDEX_Rt=5, IFID_Rs=5 -> one cycle with pc_we=0, IFID_we=0, IDEX_bubble=1; next cycle, with IDEX_mem_read=0, all enables 1.
REQ-032 IDEX_mem_read=1, IDEX_Rt=0, IFID_Rt=0 -> no stall.
REQ-033 dmem_req=1 with dmem_ready low for 3 cycles -> 3 frozen cycles with MEMWB_bubble=1; release on the ready cycle; stall_cnt=3 when the macro is defined.
REQ-034 A concurrent load-use hazard plus branch_taken during MEM_WAIT -> IFID_flush=0 and IDEX_bubble=0 until dmem_ready=1.
REQ-035 WAIT_TIMEOUT=4 with dmem_ready held low -> ERROR after 4 wait cycles, bus_err=1 stays set; rst_n pulse low -> bus_err=0, state RUN.
REQ-036 rst_n asserted mid-MEM_WAIT -> all outputs 0 at once; after release, state RUN with no residual stall.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM state encoding
// and register-file constants.
package hazard_ctrl_pkg;

    typedef logic [1:0] hz_state_t;

    localparam hz_state_t ST_RUN      = 2'd0;
    localparam hz_state_t ST_MEM_WAIT = 2'd1;
    localparam hz_state_t ST_ERROR    = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: the load in EX writes a register that
// the instruction in ID reads. Register zero never creates a hazard.
module load_use_detect
    import hazard_ctrl_pkg::*;
(
    input  logic       IDEX_mem_read,
    input  logic [4:0] IDEX_Rt,
    input  logic [4:0] IFID_Rs,
    input  logic [4:0] IFID_Rt,
    output logic       hazard
);

    assign hazard = IDEX_mem_read && (IDEX_Rt != REG_ZERO) &&
                    ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze with timeout, load-use
// stall and branch flush. Define HAZARD_STALL_CNT_EN to add the stall_cnt port.
//
// state       | meaning
// ST_RUN      | normal issue; load-use stall and branch flush resolved here
// ST_MEM_WAIT | data memory outstanding; whole pipeline frozen
// ST_ERROR    | memory timed out; frozen with bus_err until reset
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IDEX_mem_read,
    input  logic [4:0]       IDEX_Rt,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             IFID_we,
    output logic             IDEX_we,
    output logic             EXMEM_we,
    output logic             IFID_flush,
    output logic             IDEX_bubble,
    output logic             MEMWB_bubble,
`ifdef HAZARD_STALL_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
`endif
    output logic             bus_err
);

    localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);

    hz_state_t         state, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              pc_we_c, ifid_we_c, idex_we_c, exmem_we_c;
    logic              ifid_flush_c, idex_bubble_c, memwb_bubble_c;
    logic              mem_stall;

    load_use_detect u_load_use_detect (
        .IDEX_mem_read (IDEX_mem_read),
        .IDEX_Rt       (IDEX_Rt),
        .IFID_Rs       (IFID_Rs),
        .IFID_Rt       (IFID_Rt),
        .hazard        (load_use)
    );

    assign mem_stall = dmem_req && !dmem_ready;

    always_comb begin
        next_state     = state;
        pc_we_c        = 1'b0;
        ifid_we_c      = 1'b0;
        idex_we_c      = 1'b0;
        exmem_we_c     = 1'b0;
        ifid_flush_c   = 1'b0;
        idex_bubble_c  = 1'b0;
        memwb_bubble_c = 1'b0;
        case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    memwb_bubble_c = 1'b1;
                    next_state     = ST_MEM_WAIT;
                end else if (load_use) begin
                    // branch_taken is dropped here; ID holds and re-presents it
                    idex_we_c     = 1'b1;
                    exmem_we_c    = 1'b1;
                    idex_bubble_c = 1'b1;
                end else begin
                    pc_we_c      = 1'b1;
                    ifid_we_c    = 1'b1;
                    idex_we_c    = 1'b1;
                    exmem_we_c   = 1'b1;
                    ifid_flush_c = branch_taken;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    pc_we_c    = 1'b1;
                    ifid_we_c  = 1'b1;
                    idex_we_c  = 1'b1;
                    exmem_we_c = 1'b1;
                    next_state = ST_RUN;
                end else begin
                    memwb_bubble_c = 1'b1;
                    if (wait_cnt >= WAIT_LAST) next_state = ST_ERROR;
                end
            end
            ST_ERROR: next_state = ST_ERROR;
            default:  next_state = ST_RUN;
        endcase
    end

    // Reset gates every output combinationally so the pipeline sees 0 at once.
    assign pc_we        = rst_n & pc_we_c;
    assign IFID_we      = rst_n & ifid_we_c;
    assign IDEX_we      = rst_n & idex_we_c;
    assign EXMEM_we     = rst_n & exmem_we_c;
    assign IFID_flush   = rst_n & ifid_flush_c;
    assign IDEX_bubble  = rst_n & idex_bubble_c;
    assign MEMWB_bubble = rst_n & memwb_bubble_c;
    assign bus_err      = rst_n & (state == ST_ERROR);

    // The entry cycle from RUN already counts as the first wait cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            case (state)
                ST_RUN:      wait_cnt <= mem_stall ? WAIT_W'(1) : '0;
                ST_MEM_WAIT: wait_cnt <= dmem_ready ? '0 : wait_cnt + 1'b1;
                default:     wait_cnt <= wait_cnt;
            endcase
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!pc_we_c && (state != ST_ERROR) && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    logic unused_cnt_cfg;
    assign unused_cnt_cfg = |CNT_W;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (small timeout and a narrow
// stall counter so saturation is reachable).
module tb_hazard_ctrl;

    localparam int CNT_W = 3;

    // {pc_we, IFID_we, IDEX_we, EXMEM_we, IFID_flush, IDEX_bubble, MEMWB_bubble, bus_err}
    localparam logic [7:0] V_NORM = 8'b1111_0000;
    localparam logic [7:0] V_LU   = 8'b0011_0100;
    localparam logic [7:0] V_BR   = 8'b1111_1000;
    localparam logic [7:0] V_FRZ  = 8'b0000_0010;
    localparam logic [7:0] V_ERR  = 8'b0000_0001;
    localparam logic [7:0] V_ZERO = 8'b0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic IDEX_mem_read, branch_taken, dmem_req, dmem_ready;
    logic [4:0] IDEX_Rt, IFID_Rs, IFID_Rt;
    logic pc_we, IFID_we, IDEX_we, EXMEM_we, IFID_flush, IDEX_bubble, MEMWB_bubble, bus_err;
`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.WAIT_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .IDEX_mem_read (IDEX_mem_read),
        .IDEX_Rt       (IDEX_Rt),
        .IFID_Rs       (IFID_Rs),
        .IFID_Rt       (IFID_Rt),
        .branch_taken  (branch_taken),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .pc_we         (pc_we),
        .IFID_we       (IFID_we),
        .IDEX_we       (IDEX_we),
        .EXMEM_we      (EXMEM_we),
        .IFID_flush    (IFID_flush),
        .IDEX_bubble   (IDEX_bubble),
        .MEMWB_bubble  (MEMWB_bubble),
`ifdef HAZARD_STALL_CNT_EN
        .stall_cnt     (stall_cnt),
`endif
        .bus_err       (bus_err)
    );

    function automatic logic [7:0] outs();
        return {pc_we, IFID_we, IDEX_we, EXMEM_we, IFID_flush, IDEX_bubble, MEMWB_bubble, bus_err};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check outputs mid-cycle, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [7:0] exp);
        @(negedge clk);
        chk(tag, {24'd0, outs()}, {24'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int exp);
`ifdef HAZARD_STALL_CNT_EN
        chk(tag, 32'(stall_cnt), 32'(exp));
`else
        n_cmp += 0;
        if (tag.len() < 0) $display("%0d", exp);
`endif
    endtask

    task automatic idle();
        IDEX_mem_read = 1'b0;
        IDEX_Rt = 5'd0; IFID_Rs = 5'd0; IFID_Rt = 5'd0;
        branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        // Reset with hazards present: everything must read 0.
        rst_n = 1'b0;
        idle();
        IDEX_mem_read = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5;
        branch_taken = 1'b1; dmem_req = 1'b1;
        #3;
        chk("reset_outs", {24'd0, outs()}, {24'd0, V_ZERO});
        chk_cnt("reset_cnt", 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        step("idle", V_NORM);

        // Three-cycle memory wait then release.
        dmem_req = 1'b1; dmem_ready = 1'b0;
        step("mw_frz1", V_FRZ);
        step("mw_frz2", V_FRZ);
        step("mw_frz3", V_FRZ);
        dmem_ready = 1'b1;
        step("mw_release", V_NORM);
        chk_cnt("cnt_after_mw", 3);
        step("req_ready_run", V_NORM);
        idle();

        // Load-use on Rs, then clears.
        IDEX_mem_read = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5; IFID_Rt = 5'd9;
        step("lu_rs", V_LU);
        IDEX_mem_read = 1'b0;
        step("lu_clear", V_NORM);
        IDEX_mem_read = 1'b1; IDEX_Rt = 5'd7; IFID_Rs = 5'd3; IFID_Rt = 5'd7;
        step("lu_rt", V_LU);
        IDEX_Rt = 5'd0; IFID_Rs = 5'd0; IFID_Rt = 5'd0;
        step("lu_r0", V_NORM);
        IDEX_mem_read = 1'b0; IDEX_Rt = 5'd5; IFID_Rs = 5'd5;
        step("no_load", V_NORM);
        idle();
        branch_taken = 1'b1;
        step("branch", V_BR);
        IDEX_mem_read = 1'b1; IDEX_Rt = 5'd4; IFID_Rs = 5'd4;
        step("lu_over_branch", V_LU);

        // Memory stall outranks load-use and branch throughout the wait.
        dmem_req = 1'b1; dmem_ready = 1'b0;
        step("mw_hz_entry", V_FRZ);
        step("mw_hz_wait1", V_FRZ);
        step("mw_hz_wait2", V_FRZ);
        dmem_ready = 1'b1;
        step("mw_hz_release", V_NORM);
        dmem_req = 1'b0; dmem_ready = 1'b0;
        step("lu_after_mw", V_LU);
        chk_cnt("cnt_saturated", 7);
        idle();

        // Reset asserted mid-wait.
        dmem_req = 1'b1;
        step("rst_mw_entry", V_FRZ);
        rst_n = 1'b0;
        #1;
        chk("rst_mw_outs", {24'd0, outs()}, {24'd0, V_ZERO});
        chk_cnt("rst_mw_cnt", 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dmem_req = 1'b0;
        step("rst_mw_run1", V_NORM);
        step("rst_mw_run2", V_NORM);

        // Timeout into ERROR, which ignores ready and holds.
        dmem_req = 1'b1; dmem_ready = 1'b0;
        step("to_w1", V_FRZ);
        step("to_w2", V_FRZ);
        step("to_w3", V_FRZ);
        step("to_w4", V_FRZ);
        step("to_err", V_ERR);
        dmem_ready = 1'b1;
        step("err_ready", V_ERR);
        idle();
        step("err_hold", V_ERR);
        chk_cnt("cnt_err", 4);
        rst_n = 1'b0;
        #1;
        chk("err_rst_outs", {24'd0, outs()}, {24'd0, V_ZERO});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("err_rst_run", V_NORM);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
